imm_ext: RTL and testbench
==========================

Name: imm_ext

Overview:
- Registered 16-to-32-bit immediate extender for the MIPS-style datapath (I-type immediates, LUI, branch offsets).
- Selects one of four extension modes per EOp, registers the result with a valid flag, and exposes a combinational copy for same-cycle consumers.
- Sits between instruction decode and ALU/PC-offset logic.

Parameters:
- none (widths fixed: 16-bit input, 32-bit output, 2-bit opcode)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  imm/EOp valid this cycle
- imm  input  16  immediate field
- EOp  input  2  extension mode select
- ext_comb  output  32  combinational extension of current imm/EOp
- ext  output  32  registered extension result
- out_valid  output  1  ext holds a result captured on the previous valid cycle
- eop_q  output  2  EOp captured alongside ext

Behaviour:
- Extension function f(imm, EOp):
  - 2'b00 sign-extend: {{16{imm[15]}}, imm}
  - 2'b01 zero-extend: {16'h0000, imm}
  - 2'b10 load-upper: {imm, 16'h0000}
  - 2'b11 sign-extend then shift left 2: {{14{imm[15]}}, imm, 2'b00}; upper bits beyond 32 discarded
- All four codes are legal; no default/illegal path.
- ext_comb = f(imm, EOp) at all times, independent of clk, rst_n and in_valid.
- Sequential behaviour, every rising edge of clk:
  - rst_n==0: ext<=32'h0, eop_q<=2'b00, out_valid<=0. Reset takes priority over in_valid.
  - rst_n==1 and in_valid==1: ext<=f(imm,EOp), eop_q<=EOp, out_valid<=1.
  - rst_n==1 and in_valid==0: ext and eop_q hold their values; out_valid<=0.
- Latency: exactly 1 cycle from an in_valid sample to out_valid/ext.
- Throughput: one result per cycle; back-to-back valid inputs each produce their own result on consecutive cycles. No backpressure.
- Reset asserted mid-stream: the next edge clears all registers; any input sampled on that edge is dropped.
- Before the first clock edge, register state is undefined. The bench must apply reset first.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, imm=16'hFFFF -> ext=0, out_valid=0, eop_q=0. ext_comb still tracks the inputs.
- Mode sweep: imm=16'h9A49, EOp=00/01/10/11 on consecutive valid cycles -> ext=32'hFFFF9A49, 32'h00009A49, 32'h9A490000, 32'hFFFE6924 one cycle after each input. out_valid=1 throughout; eop_q matches each EOp.
- Positive immediate: imm=16'h1234, EOp=00 -> 32'h00001234; EOp=11 -> 32'h000048D0.
- Hold: after a valid imm=16'h8000/EOp=00 (result 32'hFFFF8000), drop in_valid and change imm/EOp -> ext stays 32'hFFFF8000, out_valid=0, ext_comb follows the new inputs.
- Reset mid-stream: in_valid=1 with rst_n pulsed low for one edge -> next cycle ext=0, out_valid=0; the following valid input produces a normal result.
- Boundaries: imm=16'h0000 and 16'hFFFF across all four modes -> for 16'hFFFF: 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFC; for 16'h0000: all results 0.

Source files
------------

// File: rtl/imm_ext_if.sv
// Decode-to-extender bus: immediate/mode request in, extended value and status out.
interface imm_ext_if;
  logic        in_valid;
  logic [15:0] imm;
  logic [1:0]  EOp;
  logic [31:0] ext_comb;
  logic [31:0] ext;
  logic        out_valid;
  logic [1:0]  eop_q;

  modport master (
    output in_valid, imm, EOp,
    input  ext_comb, ext, out_valid, eop_q
  );

  modport slave (
    input  in_valid, imm, EOp,
    output ext_comb, ext, out_valid, eop_q
  );
endinterface

// File: rtl/imm_ext.sv
// Registered 16-to-32-bit immediate extender (sign, zero, load-upper, branch offset)
// with a combinational copy of the extension for same-cycle consumers.
module imm_ext (
  input  logic      clk,
  input  logic      rst_n,
  imm_ext_if.slave  bus
);

  function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] eop);
    logic signed [15:0] imm_s;
    logic signed [31:0] sx;
    logic [31:0]        res;
    imm_s = imm;
    sx    = 32'(imm_s);
    res   = sx;
    case (eop)
      2'b00: res = sx;
      2'b01: res = {16'h0000, imm};
      2'b10: res = {imm, 16'h0000};
      2'b11: res = sx <<< 2;
    endcase
    return res;
  endfunction

  logic [31:0] ext_comb;
  logic [31:0] ext_d, ext_q;
  logic [1:0]  eop_d, eop_sel_q;
  logic        vld_d, vld_q;

  assign ext_comb = extend(bus.imm, bus.EOp);

  always_comb begin
    ext_d = ext_q;
    eop_d = eop_sel_q;
    vld_d = 1'b0;
    if (bus.in_valid) begin
      ext_d = ext_comb;
      eop_d = bus.EOp;
      vld_d = 1'b1;
    end
  end

  // Register stage: reset wins over a concurrent valid input, which is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_q     <= 32'h0;
      eop_sel_q <= 2'b00;
      vld_q     <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      eop_sel_q <= eop_d;
      vld_q     <= vld_d;
    end
  end

  assign bus.ext_comb  = ext_comb;
  assign bus.ext       = ext_q;
  assign bus.eop_q     = eop_sel_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_imm_ext.sv
// Directed bench for imm_ext: reset, mode sweep, hold, mid-stream reset, boundaries.
module tb_imm_ext;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  imm_ext_if bus ();

  imm_ext dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one valid input, clock it, and check the registered result.
  task automatic apply(input string tag, input logic [15:0] imm, input logic [1:0] eop,
                       input logic [31:0] exp);
    bus.in_valid = 1'b1;
    bus.imm      = imm;
    bus.EOp      = eop;
    #1;
    chk({tag, "_comb"}, bus.ext_comb, exp);
    step();
    chk({tag, "_ext"}, bus.ext, exp);
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_eop"}, 32'(bus.eop_q), 32'(eop));
  endtask

  logic [31:0] sweep_exp [4];
  logic [31:0] ones_exp  [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    sweep_exp = '{32'hFFFF9A49, 32'h00009A49, 32'h9A490000, 32'hFFFE6924};
    ones_exp  = '{32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFC};

    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.imm      = 16'hFFFF;
    bus.EOp      = 2'b00;
    #1;
    chk("rst_comb", bus.ext_comb, 32'hFFFFFFFF);
    step();
    step();
    chk("rst_ext", bus.ext, 32'h0);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_eop", 32'(bus.eop_q), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply("sweep", 16'h9A49, 2'(i), sweep_exp[i]);

    apply("pos_sx", 16'h1234, 2'b00, 32'h00001234);
    apply("pos_br", 16'h1234, 2'b11, 32'h000048D0);

    apply("hold_load", 16'h8000, 2'b00, 32'hFFFF8000);
    bus.in_valid = 1'b0;
    bus.imm      = 16'h1234;
    bus.EOp      = 2'b10;
    step();
    chk("hold_ext", bus.ext, 32'hFFFF8000);
    chk("hold_vld", 32'(bus.out_valid), 32'd0);
    chk("hold_eop", 32'(bus.eop_q), 32'd0);
    chk("hold_comb", bus.ext_comb, 32'h12340000);
    step();
    chk("hold2_ext", bus.ext, 32'hFFFF8000);

    bus.in_valid = 1'b1;
    bus.imm      = 16'h5555;
    bus.EOp      = 2'b01;
    rst_n        = 1'b0;
    step();
    chk("mrst_ext", bus.ext, 32'h0);
    chk("mrst_vld", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    apply("mrst_after", 16'h5555, 2'b01, 32'h00005555);

    for (int i = 0; i < 4; i++) apply("ones", 16'hFFFF, 2'(i), ones_exp[i]);
    for (int i = 0; i < 4; i++) apply("zero", 16'h0000, 2'(i), 32'h0);

    bus.in_valid = 1'b0;
    step();
    chk("idle_vld", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
